// File: rtl/nibble_sort_ctrl.sv
// Burst sorter: loads DEPTH nibbles, bubble-sorts them with one comparator,
// then streams them out over a valid/ready handshake.

module nibble_cmp (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       gt_o,
  output logic       lt_o,
  output logic       eq_o
);

  assign gt_o = (a_i > b_i);
  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);

endmodule

module nibble_sort_ctrl #(
  parameter int DEPTH = 4,
  localparam int S    = DEPTH * (DEPTH - 1) / 2,
  localparam int SCW  = $clog2(S + 1),
  localparam int IW   = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     in_data,
  input  logic           sort_desc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [3:0]     out_data,
  output logic           out_last,
  output logic           busy,
  output logic [SCW-1:0] swap_count
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e         state_q;
  logic [3:0]     mem_q [DEPTH];
  logic [3:0]     mem_d [DEPTH];
  logic [IW-1:0]  ld_idx_q;
  logic [IW-1:0]  p_q;
  logic [IW-1:0]  i_q;
  logic [IW-1:0]  k_q;
  logic           order_q;
  logic [SCW-1:0] sc_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [3:0]     out_data_q;
  logic           out_last_q;
  logic           busy_q;

  logic [IW-1:0]  i_nx;
  logic [IW-1:0]  k_nx;
  logic [IW-1:0]  last_i;
  logic [3:0]     cmp_a;
  logic [3:0]     cmp_b;
  logic           gt;
  logic           lt;
  logic           eq;
  logic           swap;

  assign i_nx   = i_q + IW'(1);
  assign k_nx   = k_q + IW'(1);
  assign last_i = IW'(DEPTH - 2) - p_q;
  assign cmp_a  = mem_q[i_q];
  assign cmp_b  = mem_q[i_nx];

  nibble_cmp u_cmp (
    .a_i  (cmp_a),
    .b_i  (cmp_b),
    .gt_o (gt),
    .lt_o (lt),
    .eq_o (eq)
  );

  // Equal keys never swap, which keeps the sort stable.
  assign swap = (state_q == SORT) && !eq && (order_q ? lt : gt);

  always_comb begin
    mem_d = mem_q;
    if (swap) begin
      mem_d[i_q]  = cmp_b;
      mem_d[i_nx] = cmp_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
      ld_idx_q    <= '0;
      p_q         <= '0;
      i_q         <= '0;
      k_q         <= '0;
      order_q     <= 1'b0;
      sc_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            mem_q[ld_idx_q] <= in_data;
            if (ld_idx_q == '0) order_q <= sort_desc;
            if (ld_idx_q == IW'(DEPTH - 1)) begin
              ld_idx_q   <= '0;
              p_q        <= '0;
              i_q        <= '0;
              sc_q       <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= SORT;
            end else begin
              ld_idx_q <= ld_idx_q + IW'(1);
            end
          end
        end
        SORT: begin
          for (int j = 0; j < DEPTH; j++) mem_q[j] <= mem_d[j];
          if (swap) sc_q <= sc_q + SCW'(1);
          if (i_q == last_i) begin
            i_q <= '0;
            p_q <= p_q + IW'(1);
            if (p_q == IW'(DEPTH - 2)) begin
              k_q         <= '0;
              out_valid_q <= 1'b1;
              out_data_q  <= mem_d[0];
              out_last_q  <= 1'b0;
              state_q     <= DRAIN;
            end
          end else begin
            i_q <= i_nx;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last_q) begin
              k_q         <= '0;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= LOAD;
            end else begin
              k_q        <= k_nx;
              out_data_q <= mem_q[k_nx];
              out_last_q <= (k_nx == IW'(DEPTH - 1));
            end
          end
        end
        default: begin
          state_q     <= LOAD;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign swap_count = sc_q;

endmodule

// File: tb/tb_nibble_sort_ctrl.sv
// Directed bench for nibble_sort_ctrl (DEPTH=4): table of bursts with
// hand-computed sorted outputs, plus reset-in-SORT sequence.

module tb_nibble_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       sort_desc;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;
  logic       busy;
  logic [2:0] swap_count;

  int tests  = 0;
  int failed = 0;

  nibble_sort_ctrl #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sort_desc  (sort_desc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic        desc;
    logic [15:0] exp;
    int          swaps;
    int          gap;
    logic [3:0]  stall;
    logic        tog;
    logic        holdv;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] w, input int j);
    return w[15-4*j -: 4];
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    int bad;
    bad = 0;
    for (int j = 0; j < 4; j++) begin
      if (v.gap > 0 && j > 0) begin
        in_valid = 1'b0;
        repeat (v.gap) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = nib(v.din, j);
      if (j == 0) sort_desc = v.desc;
      else if (v.tog) sort_desc = ~sort_desc;
      @(posedge clk);
      #1;
    end
    in_valid = v.holdv;
    in_data  = 4'h7;
    n = 0;
    while (!out_valid && n < 20) begin
      if (in_ready || !busy) bad++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " latency"}, n, 6);
    for (int k = 0; k < 4; k++) begin
      if (v.stall[k]) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
          if (out_data != nib(v.exp, k) || !out_valid || in_ready) bad++;
        end
      end
      chk($sformatf("%s valid%0d", nm, k), int'(out_valid), 1);
      chk($sformatf("%s data%0d", nm, k), int'(out_data), int'(nib(v.exp, k)));
      chk($sformatf("%s last%0d", nm, k), int'(out_last), (k == 3) ? 1 : 0);
      if (in_ready) bad++;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
    chk({nm, " in_ready after last"}, int'(in_ready), 1);
    chk({nm, " out_valid after last"}, int'(out_valid), 0);
    chk({nm, " busy after last"}, int'(busy), 0);
    chk({nm, " swap_count"}, int'(swap_count), v.swaps);
    chk({nm, " stall/in_ready errors"}, bad, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vec_t v;
    vecs[0] = '{16'h93F3, 1'b0, 16'h339F, 3, 0, 4'b0000, 1'b0, 1'b0};
    vecs[1] = '{16'h93F3, 1'b1, 16'hF933, 2, 0, 4'b0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0123, 1'b0, 16'h0123, 0, 0, 4'b0000, 1'b0, 1'b0};
    vecs[3] = '{16'hFEDC, 1'b0, 16'hCDEF, 6, 0, 4'b0000, 1'b0, 1'b0};
    vecs[4] = '{16'h8142, 1'b0, 16'h1248, 4, 0, 4'b0101, 1'b0, 1'b1};
    vecs[5] = '{16'h7271, 1'b1, 16'h7721, 1, 2, 4'b0000, 1'b0, 1'b0};
    vecs[6] = '{16'h93F3, 1'b0, 16'h339F, 3, 1, 4'b0000, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    sort_desc = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_data", int'(out_data), 0);
    chk("reset out_last", int'(out_last), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset swap_count", int'(swap_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++) run_vec(vecs[t], $sformatf("vec%0d", t));

    // Reset while sorting 4,3,2,1: two compares done, both swapped.
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_data  = 4'(4 - j);
      sort_desc = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midsort busy", int'(busy), 1);
    chk("midsort swap_count", int'(swap_count), 2);
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", int'(in_ready), 1);
    chk("midrst busy", int'(busy), 0);
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst swap_count", int'(swap_count), 0);
    chk("midrst out_data", int'(out_data), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid || busy || !in_ready) bad++;
    end
    chk("post-reset idle", bad, 0);
    v = '{16'h550A, 1'b0, 16'h055A, 2, 0, 4'b0000, 1'b0, 1'b0};
    run_vec(v, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
